// File: rtl/fir_channel_scheduler_if.sv
// Bundles the per-channel sample ports, the shared-FIR ports and the tagged
// result ports of the channel scheduler. The scheduler uses the master view,
// and the surrounding sources, FIR and sink use the slave view.
interface fir_channel_scheduler_if #(
  parameter int N_CH = 4,
  parameter int CH_W = 2,
  parameter int DW   = 32,
  parameter int OW   = 96
);
  logic [N_CH-1:0]    ch_valid;
  logic [N_CH*DW-1:0] ch_data;
  logic [N_CH-1:0]    ch_ready;
  logic [DW-1:0]      fir_data_in;
  logic               fir_in_valid;
  logic [CH_W-1:0]    fir_slot;
  logic [OW-1:0]      fir_data_out;
  logic               out_valid;
  logic [CH_W-1:0]    out_ch;
  logic [OW-1:0]      out_data;
  logic [15:0]        frame_cnt;
  logic               timeout_flag;

  modport master (
    input  ch_valid, ch_data, fir_data_out,
    output ch_ready, fir_data_in, fir_in_valid, fir_slot,
           out_valid, out_ch, out_data, frame_cnt, timeout_flag
  );

  modport slave (
    output ch_valid, ch_data, fir_data_out,
    input  ch_ready, fir_data_in, fir_in_valid, fir_slot,
           out_valid, out_ch, out_data, frame_cnt, timeout_flag
  );
endinterface

// File: rtl/fir_channel_scheduler.sv
// Time-multiplexes N_CH microphone channels through one shared FIR.
// One sample per channel is gathered into holding registers, the frame is
// issued in slot order 0..N_CH-1, and each FIR result comes back tagged with
// its channel through a latency-matched tag pipe.
module fir_channel_scheduler #(
  parameter int N_CH    = 4,
  parameter int CH_W    = 2,
  parameter int DW      = 32,
  parameter int OW      = 96,
  parameter int FIR_LAT = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  fir_channel_scheduler_if.master bus
);

  typedef enum logic {GATHER = 1'b0, ISSUE = 1'b1} state_t;

  localparam logic [15:0]     TMR_LAST  = 16'(TIMEOUT - 1);
  localparam logic [CH_W-1:0] SLOT_LAST = CH_W'(N_CH - 1);

  state_t          state_q;
  logic [CH_W-1:0] slot_q;
  logic [15:0]     tmr_q;
  logic [15:0]     tmr_inc;

  logic [N_CH-1:0] held_q;
  logic [N_CH-1:0] held_d;
  logic [N_CH-1:0] issue_sel;
  logic [N_CH-1:0] accept;
  logic [DW-1:0]   held_data_q [N_CH];

  logic [DW-1:0]   fir_data_in_q;
  logic            fir_in_valid_q;
  logic [CH_W-1:0] fir_slot_q;

  logic [FIR_LAT-1:0] tag_valid_q;
  logic [CH_W-1:0]    tag_ch_q [FIR_LAT];

  logic            out_valid_q;
  logic [CH_W-1:0] out_ch_q;
  logic [OW-1:0]   out_data_q;
  logic [15:0]     frame_cnt_q;
  logic            timeout_flag_q;

  // A channel is ready when empty, or in the very cycle it is being issued,
  // so a continuously valid source refills without a bubble.
  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      assign issue_sel[gi]    = (state_q == ISSUE) && (slot_q == CH_W'(gi));
      assign bus.ch_ready[gi] = ~held_q[gi] | issue_sel[gi];
      assign accept[gi]       = bus.ch_valid[gi] & bus.ch_ready[gi];
      assign held_d[gi]       = accept[gi] | (held_q[gi] & ~issue_sel[gi]);
    end
  endgenerate

  assign tmr_inc = (tmr_q == 16'hFFFF) ? tmr_q : tmr_q + 16'd1;

  // Holding registers: capture on accept; a re-accept wins over the issue clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      held_q <= '0;
      for (int i = 0; i < N_CH; i++) held_data_q[i] <= '0;
    end else begin
      held_q <= held_d;
      for (int i = 0; i < N_CH; i++) begin
        if (accept[i]) held_data_q[i] <= bus.ch_data[i*DW +: DW];
      end
    end
  end

  // Frame FSM: gather until full or timed out, then issue one slot per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= GATHER;
      slot_q         <= '0;
      tmr_q          <= '0;
      fir_data_in_q  <= '0;
      fir_in_valid_q <= 1'b0;
      fir_slot_q     <= '0;
      frame_cnt_q    <= '0;
      timeout_flag_q <= 1'b0;
    end else begin
      case (state_q)
        GATHER: begin
          fir_in_valid_q <= 1'b0;
          fir_data_in_q  <= '0;
          if (&held_q) begin
            state_q <= ISSUE;
            slot_q  <= '0;
            tmr_q   <= '0;
          end else if (tmr_q == TMR_LAST) begin
            state_q        <= ISSUE;
            slot_q         <= '0;
            tmr_q          <= '0;
            timeout_flag_q <= 1'b1;
          end else if (|held_d) begin
            tmr_q <= tmr_inc;
          end else begin
            tmr_q <= '0;
          end
        end
        ISSUE: begin
          fir_slot_q     <= slot_q;
          fir_in_valid_q <= held_q[slot_q];
          fir_data_in_q  <= held_q[slot_q] ? held_data_q[slot_q] : '0;
          tmr_q          <= '0;
          if (slot_q == SLOT_LAST) begin
            state_q     <= GATHER;
            slot_q      <= '0;
            frame_cnt_q <= frame_cnt_q + 16'd1;
          end else begin
            slot_q <= slot_q + CH_W'(1);
          end
        end
        default: state_q <= GATHER;
      endcase
    end
  end

  // Tag pipe: carries {valid, channel} alongside the FIR's own latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid_q <= '0;
      for (int i = 0; i < FIR_LAT; i++) tag_ch_q[i] <= '0;
    end else begin
      tag_valid_q <= {tag_valid_q[FIR_LAT-2:0], fir_in_valid_q};
      tag_ch_q[0] <= fir_slot_q;
      for (int i = 1; i < FIR_LAT; i++) tag_ch_q[i] <= tag_ch_q[i-1];
    end
  end

  // Result register: capture the FIR output in the cycle the tag reaches the tail.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= tag_valid_q[FIR_LAT-1];
      if (tag_valid_q[FIR_LAT-1]) begin
        out_ch_q   <= tag_ch_q[FIR_LAT-1];
        out_data_q <= bus.fir_data_out;
      end
    end
  end

  assign bus.fir_data_in  = fir_data_in_q;
  assign bus.fir_in_valid = fir_in_valid_q;
  assign bus.fir_slot     = fir_slot_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_ch       = out_ch_q;
  assign bus.out_data     = out_data_q;
  assign bus.frame_cnt    = frame_cnt_q;
  assign bus.timeout_flag = timeout_flag_q;

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Self-checking bench for fir_channel_scheduler: directed scenarios plus
// randomized traffic, compared each cycle against a frame-level model.
module tb_fir_channel_scheduler;
  localparam int N_CH = 4, CH_W = 2, DW = 32, OW = 96, FIR_LAT = 8, TIMEOUT = 1024;
  localparam int MAXC = 16384;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_channel_scheduler_if #(.N_CH(N_CH), .CH_W(CH_W), .DW(DW), .OW(OW)) bus ();

  fir_channel_scheduler #(
    .N_CH(N_CH), .CH_W(CH_W), .DW(DW), .OW(OW), .FIR_LAT(FIR_LAT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Frame-level model: which channels hold a sample, which slot (if any) is
  // being issued, how long the current frame has been waiting.
  bit          m_held [N_CH];
  logic [DW-1:0] m_data [N_CH];
  int          m_slot_ptr;
  int          m_wait;
  int          m_frames;
  bit          m_tflag;
  bit          e_fv;
  logic [DW-1:0] e_fd;
  int          e_fs;

  typedef struct {int due; int ch; int src;} pend_t;
  pend_t pend[$];
  logic [OW-1:0] hist [MAXC];

  int            first_fv_cyc, first_ov_cyc, ov_count;
  logic [DW-1:0] obs_data[$];
  int            obs_slot[$];
  int            obs_och[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin
      m_held[i] = 1'b0;
      m_data[i] = '0;
    end
    m_slot_ptr = -1;
    m_wait     = 0;
    m_frames   = 0;
    m_tflag    = 1'b0;
    e_fv       = 1'b0;
    e_fd       = '0;
    e_fs       = 0;
    pend.delete();
  endtask

  task automatic clear_obs();
    first_fv_cyc = -1;
    first_ov_cyc = -1;
    ov_count     = 0;
    obs_data.delete();
    obs_slot.delete();
    obs_och.delete();
  endtask

  // One clock: check ready, advance the model, step the clock, check outputs.
  task automatic tick();
    bit exp_rdy [N_CH];
    bit acc [N_CH];
    bit all_held, any_held;
    int k;
    for (int i = 0; i < N_CH; i++) begin
      exp_rdy[i] = !m_held[i] || (m_slot_ptr == i);
      check("ch_ready", bus.ch_ready[i], exp_rdy[i]);
    end
    if (rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < N_CH; i++) acc[i] = bus.ch_valid[i] && exp_rdy[i];
      if (m_slot_ptr >= 0) begin
        k    = m_slot_ptr;
        e_fv = m_held[k];
        e_fd = m_held[k] ? m_data[k] : '0;
        e_fs = k;
        if (m_held[k]) pend.push_back('{due: cyc + FIR_LAT + 2, ch: k, src: cyc + FIR_LAT + 1});
        m_held[k] = 1'b0;
        if (k == N_CH - 1) begin
          m_slot_ptr = -1;
          m_frames   = (m_frames + 1) % 65536;
        end else begin
          m_slot_ptr = k + 1;
        end
        m_wait = 0;
      end else begin
        e_fv = 1'b0;
        e_fd = '0;
        all_held = 1'b1;
        for (int i = 0; i < N_CH; i++) all_held &= m_held[i];
        if (all_held) begin
          m_slot_ptr = 0;
          m_wait     = 0;
        end else if (m_wait == TIMEOUT - 1) begin
          m_slot_ptr = 0;
          m_wait     = 0;
          m_tflag    = 1'b1;
        end
      end
      for (int i = 0; i < N_CH; i++) begin
        if (acc[i]) begin
          m_held[i] = 1'b1;
          m_data[i] = bus.ch_data[i*DW +: DW];
        end
      end
      if (m_slot_ptr < 0) begin
        any_held = 1'b0;
        for (int i = 0; i < N_CH; i++) any_held |= m_held[i];
        m_wait = any_held ? ((m_wait < 65535) ? m_wait + 1 : 65535) : 0;
      end
    end
    hist[cyc % MAXC] = bus.fir_data_out;
    @(posedge clk);
    #1;
    cyc++;
    check("fir_in_valid", bus.fir_in_valid, e_fv);
    check("fir_data_in", bus.fir_data_in, e_fd);
    check("fir_slot", bus.fir_slot, e_fs);
    check("frame_cnt", bus.frame_cnt, m_frames);
    check("timeout_flag", bus.timeout_flag, m_tflag);
    if (pend.size() > 0 && pend[0].due == cyc) begin
      check("out_valid", bus.out_valid, 1);
      check("out_ch", bus.out_ch, pend[0].ch);
      check("out_data", bus.out_data, hist[pend[0].src % MAXC]);
      void'(pend.pop_front());
    end else begin
      check("out_valid", bus.out_valid, 0);
    end
    if (bus.fir_in_valid) begin
      if (first_fv_cyc < 0) first_fv_cyc = cyc;
      obs_data.push_back(bus.fir_data_in);
      obs_slot.push_back(int'(bus.fir_slot));
    end
    if (bus.out_valid) begin
      if (first_ov_cyc < 0) first_ov_cyc = cyc;
      ov_count++;
      obs_och.push_back(int'(bus.out_ch));
      $display("OUT cyc=%0d ch=%0d data=%0h", cyc, bus.out_ch, bus.out_data);
    end
    bus.fir_data_out = {$urandom, $urandom, $urandom};
  endtask

  task automatic do_reset();
    bus.ch_valid = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drive(input logic [N_CH-1:0] v);
    bus.ch_valid = v;
    for (int i = 0; i < N_CH; i++) bus.ch_data[i*DW +: DW] = $urandom;
  endtask

  task automatic idle(input int n);
    bus.ch_valid = '0;
    for (int t = 0; t < n; t++) tick();
  endtask

  int c0;
  int zrun [N_CH];
  int zmax;
  int cnt3;
  logic [N_CH-1:0] v;

  initial begin
    bus.ch_valid     = '0;
    bus.ch_data      = '0;
    bus.fir_data_out = '0;
    model_reset();
    clear_obs();

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_frame_cnt", bus.frame_cnt, 16'h0000);
    check("rst_ch_ready", bus.ch_ready, 4'hF);
    check("rst_fir_slot", bus.fir_slot, 2'd0);
    check("rst_timeout", bus.timeout_flag, 1'b0);
    rst = 1'b0;

    // One full frame with samples 10,20,30,40
    clear_obs();
    c0 = cyc;
    bus.ch_valid = 4'hF;
    bus.ch_data  = {32'd40, 32'd30, 32'd20, 32'd10};
    tick();
    idle(20);
    check("f1_count", obs_data.size(), 4);
    for (int i = 0; i < 4 && i < obs_data.size(); i++) begin
      check("f1_data", obs_data[i], (i + 1) * 10);
      check("f1_slot", obs_slot[i], i);
    end
    for (int i = 0; i < 4 && i < obs_och.size(); i++) check("f1_out_ch", obs_och[i], i);
    check("f1_first_fir", first_fv_cyc - c0, 3);
    check("f1_first_out", first_ov_cyc - c0, FIR_LAT + 4);
    check("f1_frames", bus.frame_cnt, 16'd1);

    // Timeout: channel 3 never delivers
    do_reset();
    clear_obs();
    c0 = cyc;
    drive(4'b0111);
    tick();
    idle(1100);
    check("to_first_fir", first_fv_cyc - c0, TIMEOUT + 1);
    check("to_fir_count", obs_data.size(), 3);
    check("to_out_count", ov_count, 3);
    cnt3 = 0;
    foreach (obs_och[i]) if (obs_och[i] == 3) cnt3++;
    check("to_no_ch3", cnt3, 0);
    check("to_flag", bus.timeout_flag, 1'b1);

    // Continuously valid for 20 frames
    do_reset();
    clear_obs();
    for (int i = 0; i < N_CH; i++) zrun[i] = 0;
    zmax = 0;
    c0 = cyc;
    for (int t = 0; t < 101; t++) begin
      drive(4'hF);
      tick();
      for (int i = 0; i < N_CH; i++) begin
        zrun[i] = bus.ch_ready[i] ? 0 : zrun[i] + 1;
        if (zrun[i] > zmax) zmax = zrun[i];
      end
      if (cyc == c0 + 100) check("bb_frames19", bus.frame_cnt, 16'd19);
      if (cyc == c0 + 101) check("bb_frames20", bus.frame_cnt, 16'd20);
    end
    check("bb_ready_gap", (zmax <= 5), 1'b1);
    idle(20);

    // Second sample on ch1 waits until slot 1 issues
    do_reset();
    clear_obs();
    bus.ch_valid = 4'b0010;
    bus.ch_data[1*DW +: DW] = 32'h111;
    tick();
    bus.ch_data[1*DW +: DW] = 32'h222;
    for (int t = 0; t < 4; t++) tick();
    check("hold_ch1_busy", bus.ch_ready[1], 1'b0);
    bus.ch_valid = 4'b1111;
    tick();
    bus.ch_valid = 4'b0010;
    for (int t = 0; t < 5; t++) tick();
    bus.ch_valid = 4'b0000;
    tick();
    drive(4'b1101);
    tick();
    idle(20);
    check("hold_fir_count", obs_data.size(), 8);
    cnt3 = 0;
    foreach (obs_slot[i]) begin
      if (obs_slot[i] == 1) begin
        check("hold_ch1_data", obs_data[i], (cnt3 == 0) ? 32'h111 : 32'h222);
        cnt3++;
      end
    end
    check("hold_ch1_count", cnt3, 2);

    // Reset while slot 2 is being issued
    do_reset();
    c0 = cyc;
    drive(4'hF);
    tick();
    idle(3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_obs();
    check("mid_rst_fir_valid", bus.fir_in_valid, 1'b0);
    check("mid_rst_ready", bus.ch_ready, 4'hF);
    idle(25);
    check("mid_rst_no_out", ov_count, 0);
    check("mid_rst_frames", bus.frame_cnt, 16'd0);

    // Random traffic with occasional resets
    do_reset();
    for (int t = 0; t < 2500; t++) begin
      for (int i = 0; i < N_CH; i++) v[i] = ($urandom_range(0, 9) < 4);
      drive(v);
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;
    // Random traffic with a starving channel to provoke timeouts
    for (int t = 0; t < 2500; t++) begin
      for (int i = 0; i < N_CH - 1; i++) v[i] = ($urandom_range(0, 1) == 1);
      v[N_CH-1] = ($urandom_range(0, 699) == 0);
      drive(v);
      tick();
    end
    idle(20);

    // frame_cnt wrap
    do_reset();
    force dut.frame_cnt_q = 16'hFFFF;
    #1;
    release dut.frame_cnt_q;
    m_frames = 65535;
    drive(4'hF);
    tick();
    idle(15);
    check("wrap_frames", bus.frame_cnt, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
